cascade_scan_ctrl: RTL

Parametrised multi-scale sequencer for the Haar cascade face detector; successor to the single-scale `control_fsm`. It owns the window scan counters, the stage index and the scale index internally, and adds a backpressured detection output. It sits between the integral-image engine, the stage evaluator and the detection result sink.

---
 rtl/cascade_scan_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/cascade_scan_ctrl.sv
// cascade_scan_ctrl: multi-scale window/stage sequencer for the Haar cascade face detector.
// Owns the raster scan, stage and scale counters and presents backpressured detections.
module cascade_scan_ctrl #(
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 64,
    parameter int WIN        = 24,
    parameter int STEP       = 2,
    parameter int NUM_STAGES = 22,
    parameter int NUM_SCALES = 3,
    localparam int XW = $clog2(IMG_W),
    localparam int YW = $clog2(IMG_H),
    localparam int SW = $clog2(NUM_STAGES + 1),
    localparam int CW = $clog2(NUM_SCALES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          ii_start,
    input  logic          ii_done,
    output logic          stage_start,
    input  logic          stage_done,
    input  logic          stage_passed,
    output logic [XW-1:0] win_x,
    output logic [YW-1:0] win_y,
    output logic [SW-1:0] stage_idx,
    output logic [CW-1:0] scale_idx,
    output logic          det_valid,
    input  logic          det_ready,
    output logic [XW-1:0] det_x,
    output logic [YW-1:0] det_y,
    output logic [CW-1:0] det_scale,
    output logic [15:0]   det_count,
    output logic          busy,
    output logic          done,
    output logic [2:0]    state
);

    // Largest window origin reachable with the given stride.
    localparam int XMAX = ((IMG_W - WIN) / STEP) * STEP;
    localparam int YMAX = ((IMG_H - WIN) / STEP) * STEP;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        COMPUTE_II  = 3'd1,
        INIT_SCAN   = 3'd2,
        EVAL        = 3'd3,
        NEXT_STAGE  = 3'd4,
        NEXT_WINDOW = 3'd5,
        FINISH      = 3'd6,
        REPORT      = 3'd7
    } state_t;

    state_t        state_q, state_n;
    logic [XW-1:0] win_x_n, det_x_n;
    logic [YW-1:0] win_y_n, det_y_n;
    logic [SW-1:0] stage_idx_n;
    logic [CW-1:0] scale_idx_n, det_scale_n;
    logic [15:0]   det_count_n;
    logic          ii_start_n, stage_start_n, det_valid_n, busy_n, done_n;

    logic last_stage, last_win, last_scale, x_wrap;

    assign last_stage = (stage_idx == SW'(NUM_STAGES - 1));
    assign last_scale = (scale_idx == CW'(NUM_SCALES - 1));
    assign last_win   = (win_x == XW'(XMAX)) && (win_y == YW'(YMAX));
    assign x_wrap     = (int'(win_x) + STEP) > XMAX;

    always_comb begin
        state_n     = state_q;
        win_x_n     = win_x;
        win_y_n     = win_y;
        stage_idx_n = stage_idx;
        scale_idx_n = scale_idx;
        det_x_n     = det_x;
        det_y_n     = det_y;
        det_scale_n = det_scale;
        det_count_n = det_count;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_n     = COMPUTE_II;
                    scale_idx_n = '0;
                    det_count_n = '0;
                end
            end
            COMPUTE_II: begin
                if (ii_done) state_n = INIT_SCAN;
            end
            INIT_SCAN: begin
                win_x_n     = '0;
                win_y_n     = '0;
                stage_idx_n = '0;
                state_n     = EVAL;
            end
            EVAL: begin
                if (stage_done) begin
                    if (!stage_passed) begin
                        state_n = NEXT_WINDOW;
                    end else if (last_stage) begin
                        state_n     = REPORT;
                        det_x_n     = win_x;
                        det_y_n     = win_y;
                        det_scale_n = scale_idx;
                    end else begin
                        state_n = NEXT_STAGE;
                    end
                end
            end
            NEXT_STAGE: begin
                stage_idx_n = stage_idx + SW'(1);
                state_n     = EVAL;
            end
            REPORT: begin
                if (det_ready) begin
                    if (det_count != 16'hFFFF) det_count_n = det_count + 16'd1;
                    state_n = NEXT_WINDOW;
                end
            end
            NEXT_WINDOW: begin
                stage_idx_n = '0;
                if (!last_win) begin
                    state_n = EVAL;
                    if (x_wrap) begin
                        win_x_n = '0;
                        win_y_n = win_y + YW'(STEP);
                    end else begin
                        win_x_n = win_x + XW'(STEP);
                    end
                end else if (!last_scale) begin
                    scale_idx_n = scale_idx + CW'(1);
                    state_n     = COMPUTE_II;
                end else begin
                    state_n = FINISH;
                end
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Pulses and flags are derived from the upcoming state so they line up with it.
        ii_start_n    = (state_n == COMPUTE_II) && (state_q != COMPUTE_II);
        stage_start_n = (state_n == EVAL) && (state_q != EVAL);
        det_valid_n   = (state_n == REPORT);
        done_n        = (state_n == FINISH);
        busy_n        = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            win_x       <= '0;
            win_y       <= '0;
            stage_idx   <= '0;
            scale_idx   <= '0;
            det_x       <= '0;
            det_y       <= '0;
            det_scale   <= '0;
            det_count   <= '0;
            det_valid   <= 1'b0;
            ii_start    <= 1'b0;
            stage_start <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_n;
            win_x       <= win_x_n;
            win_y       <= win_y_n;
            stage_idx   <= stage_idx_n;
            scale_idx   <= scale_idx_n;
            det_x       <= det_x_n;
            det_y       <= det_y_n;
            det_scale   <= det_scale_n;
            det_count   <= det_count_n;
            det_valid   <= det_valid_n;
            ii_start    <= ii_start_n;
            stage_start <= stage_start_n;
            done        <= done_n;
            busy        <= busy_n;
        end
    end

    assign state = state_q;

endmodule
